// File: rtl/mux_scanner.sv
// mux_scanner: steps the select of an external 4:1 multiplexer through
// channels 0..3, holds each select for SETTLE_CYC cycles, samples the mux
// output at the end of each settle window and presents the 4-bit result
// as a frame behind a valid/ready handshake. A frame that completes while
// the previous one is still unaccepted is dropped and flagged on overrun.
module mux_scanner #(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       din,
    output logic [1:0] sel,
    output logic [3:0] frame_data,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Last settle count of a select window; cnt is wide enough for 16.
    localparam logic [4:0] CNT_LAST = 5'(SETTLE_CYC - 1);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [4:0] cnt_q, cnt_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] frame_data_q, frame_data_d;
    logic       frame_valid_q, frame_valid_d;
    logic       busy_q, busy_d;
    logic       overrun_q, overrun_d;

    logic       settle_done_s;
    logic       frame_done_s;
    logic [3:0] frame_next_s;

    // Replace one bit of a 4-bit word; used to merge the current sample
    // into the shadow so a completing frame includes its last bit.
    function automatic logic [3:0] merge_bit(
        input logic [3:0] word,
        input logic [1:0] idx,
        input logic       b
    );
        logic [3:0] res;
        res      = word;
        res[idx] = b;
        return res;
    endfunction

    // Next-state, scan sequencing and frame handshake logic.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = frame_valid_q;
        busy_d        = busy_q;
        overrun_d     = overrun_q;

        settle_done_s = (state_q == SCAN) && (cnt_q == CNT_LAST);
        frame_done_s  = settle_done_s && (sel_q == 2'd3);
        frame_next_s  = merge_bit(shadow_q, sel_q, din);

        case (state_q)
            IDLE: begin
                sel_d = 2'd0;
                cnt_d = 5'd0;
                if (start) begin
                    state_d   = SCAN;
                    busy_d    = 1'b1;
                    overrun_d = 1'b0;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            SCAN: begin
                if (settle_done_s) begin
                    shadow_d = frame_next_s;
                    cnt_d    = 5'd0;
                    sel_d    = sel_q + 2'd1;
                    if (frame_done_s && !cont) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = SCAN;
                        busy_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 2'd0;
                cnt_d   = 5'd0;
                busy_d  = 1'b0;
            end
        endcase

        // A completing frame either replaces an accepted/empty slot or is
        // dropped; acceptance alone empties the slot.
        if (frame_done_s && (!frame_valid_q || frame_ready)) begin
            frame_data_d  = frame_next_s;
            frame_valid_d = 1'b1;
        end else if (frame_done_s) begin
            overrun_d = 1'b1;
        end else if (frame_valid_q && frame_ready) begin
            frame_valid_d = 1'b0;
        end else begin
            frame_valid_d = frame_valid_q;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sel_q         <= 2'd0;
            cnt_q         <= 5'd0;
            shadow_q      <= 4'd0;
            frame_data_q  <= 4'd0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
        end
    end

    assign sel         = sel_q;
    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_mux_scanner.sv
// Directed bench for mux_scanner with a frame-level reference model.
module tb_mux_scanner;

    localparam int S = 2;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       cont;
    logic       din;
    logic [1:0] sel;
    logic [3:0] frame_data;
    logic       frame_valid;
    logic       frame_ready;
    logic       busy;
    logic       overrun;

    logic [3:0] mux_in;   // bit k = mux input k (a=0, b=1, c=2, d=3)
    logic       chk_en;

    int n_checks;
    int n_fail;

    mux_scanner #(.SETTLE_CYC(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cont        (cont),
        .din         (din),
        .sel         (sel),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .busy        (busy),
        .overrun     (overrun)
    );

    // Downstream 4:1 multiplexer
    assign din = mux_in[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is 4*S cycles long; position ph in the
    // frame selects channel ph/S and samples at the end of each window.
    logic       m_act;
    int         m_ph;
    logic [3:0] m_shadow;
    logic [3:0] m_fd;
    logic       m_fv;
    logic       m_ov;

    always @(posedge clk or negedge rst_n) begin : model
        logic [3:0] sh;
        if (!rst_n) begin
            m_act    <= 1'b0;
            m_ph     <= 0;
            m_shadow <= 4'd0;
            m_fd     <= 4'd0;
            m_fv     <= 1'b0;
            m_ov     <= 1'b0;
        end else if (!m_act) begin
            if (start) begin
                m_act <= 1'b1;
                m_ph  <= 0;
                m_ov  <= 1'b0;
            end
            if (m_fv && frame_ready) m_fv <= 1'b0;
        end else begin
            sh = m_shadow;
            if ((m_ph % S) == S - 1) sh[m_ph / S] = mux_in[m_ph / S];
            m_shadow <= sh;
            if (m_ph == 4 * S - 1) begin
                m_ph  <= 0;
                m_act <= cont;
                if (!m_fv || frame_ready) begin
                    m_fd <= sh;
                    m_fv <= 1'b1;
                end else begin
                    m_ov <= 1'b1;
                end
            end else begin
                m_ph <= m_ph + 1;
                if (m_fv && frame_ready) m_fv <= 1'b0;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_sel", 32'(sel), m_act ? 32'(m_ph / S) : 32'd0);
            chk("cmp_busy", 32'(busy), 32'(m_act));
            chk("cmp_fdata", 32'(frame_data), 32'(m_fd));
            chk("cmp_fvalid", 32'(frame_valid), 32'(m_fv));
            chk("cmp_overrun", 32'(overrun), 32'(m_ov));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for frame_valid high; returns ticks taken.
    task automatic wait_fv(output int n);
        n = 0;
        while (!frame_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        n_checks    = 0;
        n_fail      = 0;
        chk_en      = 1'b0;
        rst_n       = 1'b0;
        start       = 1'b0;
        cont        = 1'b0;
        frame_ready = 1'b0;
        mux_in      = 4'b1001;
        #2;
        chk("reset_outputs", {27'd0, sel, frame_valid, busy, overrun}, 32'd0);
        chk("reset_fdata", 32'(frame_data), 32'd0);
        tick();
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        // Single scan, a=1 b=0 c=0 d=1
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("scan_busy", 32'(busy), 32'd1);
        chk("scan_sel0", 32'(sel), 32'd0);
        wait_fv(n);
        chk("single_latency", 32'(n), 32'd8);
        chk("single_fdata", 32'(frame_data), 32'h9);
        chk("single_idle", 32'(busy), 32'd0);

        // Handshake: hold, then accept
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_fdata", 32'(frame_data), 32'h9);
            chk("hold_fvalid", 32'(frame_valid), 32'd1);
        end
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        chk("accept_clear", 32'(frame_valid), 32'd0);

        // Continuous mode, ready tied high, inputs change in frame 2
        cont        = 1'b1;
        frame_ready = 1'b1;
        start       = 1'b1;
        tick();
        start = 1'b0;
        wait_fv(n);
        chk("cont_first_lat", 32'(n), 32'd8);
        chk("cont_first_data", 32'(frame_data), 32'h9);
        mux_in = 4'b0110;
        tick();
        n = 1;
        while (!frame_valid && n < 20) begin
            tick();
            n++;
        end
        chk("cont_spacing", 32'(n), 32'd8);
        chk("cont_second_data", 32'(frame_data), 32'h6);
        chk("cont_no_overrun", 32'(overrun), 32'd0);
        cont = 1'b0;
        wait_idle("cont_stop_idle");
        tick();
        tick();

        // Overrun: continuous, ready low
        frame_ready = 1'b0;
        mux_in      = 4'b1001;
        cont        = 1'b1;
        start       = 1'b1;
        tick();
        start = 1'b0;
        wait_fv(n);
        chk("ovr_first_lat", 32'(n), 32'd8);
        chk("ovr_first_data", 32'(frame_data), 32'h9);
        mux_in = 4'b0110;
        for (int i = 0; i < 8; i++) tick();
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_data_kept", 32'(frame_data), 32'h9);
        chk("ovr_valid_kept", 32'(frame_valid), 32'd1);
        cont = 1'b0;
        wait_idle("ovr_stop_idle");
        chk("ovr_sticky", 32'(overrun), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // Simultaneous accept and completion
        for (int i = 0; i < 7; i++) tick();
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        chk("simul_valid", 32'(frame_valid), 32'd1);
        chk("simul_data", 32'(frame_data), 32'h6);
        chk("simul_overrun", 32'(overrun), 32'd0);
        chk("simul_idle", 32'(busy), 32'd0);

        // Reset mid-scan at sel==2
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_reset_sel", 32'(sel), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", {27'd0, sel, frame_valid, busy, overrun}, 32'd0);
        chk("async_reset_fdata", 32'(frame_data), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("post_reset_valid", 32'(frame_valid), 32'd0);
            chk("post_reset_busy", 32'(busy), 32'd0);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scanner.md
MUX_SCANNER -- requirements
Module: mux_scanner

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 2, giving the cycles each select value is held before sampling (legal range 1..16).
REQ-002 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, which requests a scan when sampled high in IDLE.
REQ-005 The block SHALL have port cont, input, 1 bit, for continuous mode: when high at frame completion, rescanning starts immediately.
REQ-006 The block SHALL have port din, input, 1 bit, the output of the downstream 4:1 multiplexer.
REQ-007 The block SHALL have port sel, output, 2 bits, the channel select driven into the 4:1 multiplexer.
REQ-008 The block SHALL have port frame_data, output, 4 bits, where bit k is the din value sampled while sel==k.
REQ-009 The block SHALL have port frame_valid, output, 1 bit, which is high while frame_data holds an unaccepted frame.
REQ-010 The block SHALL have port frame_ready, input, 1 bit, with which the consumer accepts a frame.
REQ-011 The block SHALL have port busy, output, 1 bit, which is high in state SCAN.
REQ-012 The block SHALL have port overrun, output, 1 bit, a sticky flag meaning a completed frame was dropped.

Function
REQ-013 The block SHALL implement a two-state FSM with states IDLE and SCAN.
REQ-014 The FSM SHALL move IDLE->SCAN on start=1, setting sel=0, the settle counter cnt=0, and overrun=0.
REQ-015 In SCAN, cnt SHALL increment each cycle; when cnt==SETTLE_CYC-1, the block SHALL capture din into bit sel of the internal shadow register, clear cnt, and increment sel.
REQ-016 The block SHALL treat the capture at sel==3 as frame completion; sel SHALL wrap to 0.
REQ-017 At frame completion, if frame_valid==0 or frame_ready==1 in the same cycle, the block SHALL load the complete 4-bit frame (including the bit captured this cycle) into frame_data and set frame_valid=1.
REQ-018 At frame completion, if frame_valid==1 and frame_ready==0, the block SHALL drop the new frame, keep frame_data unchanged, and set overrun=1.
REQ-019 After frame completion, the FSM SHALL stay in SCAN if cont==1; otherwise it SHALL go to IDLE with sel held at 0.
REQ-020 Deasserting cont mid-frame SHALL NOT abort the scan; the current frame SHALL complete and the FSM SHALL then go to IDLE.
REQ-021 The block SHALL ignore start while in SCAN.
REQ-022 frame_valid SHALL clear on any cycle with frame_valid==1, frame_ready==1 and no simultaneous load; frame_ready SHALL have no effect when frame_valid==0.
REQ-023 Once asserted, frame_valid and frame_data SHALL stay stable until accepted.
REQ-024 Latency: with start sampled at edge 0, the block SHALL assert frame_valid after edge 4*SETTLE_CYC (edge 8 for the default).
REQ-025 In continuous mode, the block SHALL produce frames every 4*SETTLE_CYC cycles with no gap cycle.
REQ-026 The block SHALL clear overrun only on reset or on an IDLE->SCAN transition.

Reset
REQ-027 When rst_n is low, the block SHALL asynchronously force state=IDLE, sel=0, cnt=0, shadow=0, frame_data=0, frame_valid=0, busy=0, overrun=0.
REQ-028 A reset asserted mid-scan SHALL discard the partial frame; after release the block SHALL wait in IDLE for start.
REQ-029 Reset release SHALL take effect on the first rising clk edge with rst_n high.

Verification
REQ-030 Single scan: mux inputs a=1, b=0, c=0, d=1; SETTLE_CYC=2; start pulse with cont=0 -> sel steps 0,1,2,3 (2 cycles each), frame_valid rises 8 cycles after start, frame_data=4'b1001, then IDLE with busy=0.
REQ-031 Handshake: frame_ready held low for 5 cycles after frame_valid -> frame_data is stable at 4'b1001; frame_ready=1 for 1 cycle -> frame_valid=0 on the next cycle.
REQ-032 Continuous mode with frame_ready tied high: inputs changed to a=0, b=1, c=1, d=0 during the second frame -> frames are spaced 8 cycles apart, the second frame (at the earliest) reflects the new values (4'b0110), and overrun=0.
REQ-033 Overrun: continuous mode with frame_ready=0 -> the first frame is held, overrun=1 at the second completion, frame_data unchanged; a subsequent start from IDLE clears overrun.
REQ-034 Simultaneous event: frame_ready=1 exactly on a completion cycle with frame_valid=1 -> the new frame is loaded, frame_valid stays 1, and overrun=0.
REQ-035 Reset mid-scan: rst_n pulled low while sel=2 -> all outputs are 0 immediately, without waiting for clk; after release the block stays in IDLE and does not assert frame_valid until a new start.
